// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings, memory-access FSM states and error cause codes.
package riscv_pkg;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } mau_state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrMisalign = 2'b01,
        ErrTimeout  = 2'b10,
        ErrIllegal  = 2'b11
    } err_cause_e;

    function automatic logic is_legal_load(input logic [2:0] f3);
        return (f3 == F3Byte) || (f3 == F3Half) || (f3 == F3Word) ||
               (f3 == F3ByteU) || (f3 == F3HalfU);
    endfunction

    function automatic logic is_legal_store(input logic [2:0] f3);
        return (f3 == F3Byte) || (f3 == F3Half) || (f3 == F3Word);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data, plus load
// lane extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halves only look at off[1]; a stray off[0] is dropped here by construction.
    always_comb begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        case (st_size_i)
            2'b00: begin
                be_o      = 4'b0001 << st_off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be_o      = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: begin
                be_o      = 4'b1111;
                st_data_o = st_data_i;
            end
        endcase
    end

    assign ld_byte = ld_data_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_off_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

    always_comb begin
        ld_data_o = '0;
        case (ld_funct3_i)
            F3Byte:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3Half:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3Word:  ld_data_o = ld_data_i;
            F3ByteU: ld_data_o = {24'h0, ld_byte};
            F3HalfU: ld_data_o = {16'h0, ld_half};
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus access unit (IDLE/REQ/DONE) with bus timeout.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic        stall_m,
    output logic [31:0] rdata_m,
    output logic        done_m,
    output logic        err_m,
    output logic [1:0]  err_cause_m,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    mau_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            bus_req_q, bus_we_q, done_q, err_q;
    logic [1:0]      cause_q;
    logic [31:0]     bus_addr_q, bus_wdata_q, rdata_q;
    logic [3:0]      bus_be_q;

    logic            access, is_store, legal;
    logic [3:0]      be_c;
    logic [31:0]     st_data_c, ld_data_c;

    assign access   = mem_read_m | mem_write_m;
    assign is_store = mem_write_m;  // a simultaneous read is dropped in favour of the store
    assign legal    = is_store ? is_legal_store(funct3_m) : is_legal_load(funct3_m);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3_m[1:0] == 2'b01) && addr_m[0]) ||
                        ((funct3_m[1:0] == 2'b10) && (addr_m[1:0] != 2'b00));
`endif

    lsu_align u_align (
        .st_size_i   (funct3_m[1:0]),
        .st_off_i    (addr_m[1:0]),
        .st_data_i   (wdata_m),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_data_i   (bus_rdata),
        .be_o        (be_c),
        .st_data_o   (st_data_c),
        .ld_data_o   (ld_data_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cause_q     <= ErrNone;
            rdata_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= ErrNone;
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        if (!legal) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            cause_q <= ErrIllegal;
                            rdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        end else if (misaligned) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            cause_q <= ErrMisalign;
                            rdata_q <= '0;
`endif
                        end else begin
                            state_q     <= StReq;
                            cnt_q       <= '0;
                            f3_q        <= funct3_m;
                            off_q       <= addr_m[1:0];
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= is_store;
                            bus_addr_q  <= {addr_m[31:2], 2'b00};
                            bus_be_q    <= be_c;
                            bus_wdata_q <= is_store ? st_data_c : '0;
                        end
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        state_q   <= StDone;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!bus_we_q) begin
                            rdata_q <= ld_data_c;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StDone;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        cause_q   <= ErrTimeout;
                        rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Gated by reset so the stall also reads 0 while the unit is held in reset.
    assign stall_m = reset & (((state_q == StIdle) & access) | (state_q == StReq));

    assign rdata_m     = rdata_q;
    assign done_m      = done_q;
    assign err_m       = err_q;
    assign err_cause_m = cause_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then random accesses
// against a size/offset arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, wdata_m;
    logic        stall_m, done_m, err_m;
    logic [31:0] rdata_m;
    logic [1:0]  err_cause_m;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read_m  (mem_read_m),
        .mem_write_m (mem_write_m),
        .funct3_m    (funct3_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .stall_m     (stall_m),
        .rdata_m     (rdata_m),
        .done_m      (done_m),
        .err_m       (err_m),
        .err_cause_m (err_cause_m),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from the IDLE cycle through DONE, with the bench acting as the bus.
    task automatic do_access(input string name, input bit rd, input bit wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd_val,
                             input int waits, input bit never_ack);
        bit              legal, mis, txn, got;
        int              size, off, cyc, stalls, reqc, exp_lat;
        longint unsigned mask;
        logic [31:0]     exp_be, exp_wd, piece, v, exp_cause, exp_rd;

        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        mis   = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis = legal && ((addr % size) != 0);
`endif
        txn    = legal && !mis;
        off    = int'(addr & 32'd3) & ~(size - 1);
        exp_be = ((32'd1 << size) - 1) << off;
        mask   = (64'd1 << (8 * size)) - 1;
        piece  = wd & mask[31:0];
        exp_wd = '0;
        for (int k = 0; k < 4 / size; k++) exp_wd |= piece << (8 * size * k);
        v = (rd_val >> (8 * off)) & mask[31:0];
        if (!f3[2] && size < 4 && v[8 * size - 1]) v |= ~mask[31:0];
        exp_cause = !legal ? 32'd3 : mis ? 32'd1 : never_ack ? 32'd2 : 32'd0;
        exp_rd    = (never_ack || !txn) ? 32'd0 : v;
        exp_lat   = !txn ? 2 : never_ack ? TIMEOUT + 2 : waits + 3;

        mem_read_m  = rd;
        mem_write_m = wr;
        funct3_m    = f3;
        addr_m      = addr;
        wdata_m     = wd;
        #1;
        check({name, ".stall_idle"}, 32'(stall_m), 32'd1);
        cyc    = 1;
        stalls = 1;
        reqc   = 0;
        got    = 1'b0;
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            if (done_m) begin
                got     = 1'b1;
                bus_ack = 1'b0;
                check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
                check({name, ".stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
                check({name, ".stall_done"}, 32'(stall_m), 32'd0);
                check({name, ".bus_req_done"}, 32'(bus_req), 32'd0);
                check({name, ".err"}, 32'(err_m), 32'(exp_cause != 0));
                check({name, ".cause"}, 32'(err_cause_m), exp_cause);
                if (!wr && legal) check({name, ".rdata"}, rdata_m, exp_rd);
                mem_read_m  = 1'b0;
                mem_write_m = 1'b0;
            end else begin
                if (stall_m) stalls++;
                check({name, ".bus_req"}, 32'(bus_req), 32'(txn));
                if (bus_req && reqc == 0) begin
                    check({name, ".bus_we"}, 32'(bus_we), 32'(wr));
                    check({name, ".bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
                    check({name, ".bus_be"}, 32'(bus_be), exp_be);
                    if (wr) check({name, ".bus_wdata"}, bus_wdata, exp_wd);
                end
                reqc++;
                if (!never_ack && reqc == waits + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_val;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
        if (!got) check({name, ".done_seen"}, 32'd0, 32'd1);
        tick();
        check({name, ".done_pulse"}, 32'(done_m), 32'd0);
        if (!wr && legal) check({name, ".rdata_hold"}, rdata_m, exp_rd);
    endtask

    initial begin
        reset       = 1'b0;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        funct3_m    = '0;
        addr_m      = '0;
        wdata_m     = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        #23;
        check("rst.bus_req", 32'(bus_req), 32'd0);
        check("rst.done", 32'(done_m), 32'd0);
        check("rst.stall", 32'(stall_m), 32'd0);
        check("rst.rdata", rdata_m, 32'd0);
        check("rst.bus_addr", bus_addr, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        do_access("sw",    1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        do_access("lb",    1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_FFFF, 2, 1'b0);
        do_access("lbu",   1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_FFFF, 2, 1'b0);
        do_access("sh",    1'b0, 1'b1, 3'd1, 32'h302, 32'h0000_ABCD, 32'h0, 1, 1'b0);
        do_access("lw_mis", 1'b1, 1'b0, 3'd2, 32'h401, 32'h0, 32'h1234_5678, 0, 1'b0);
        do_access("lh_mis", 1'b1, 1'b0, 3'd1, 32'h503, 32'h0, 32'hC001_7FEE, 1, 1'b0);
        do_access("ill_ld", 1'b1, 1'b0, 3'd3, 32'h600, 32'h0, 32'h0, 0, 1'b0);
        do_access("ill_st", 1'b0, 1'b1, 3'd4, 32'h604, 32'h55, 32'h0, 0, 1'b0);
        do_access("rd_wr",  1'b1, 1'b1, 3'd0, 32'h701, 32'h0000_00A5, 32'h0, 0, 1'b0);
        do_access("lhu",    1'b1, 1'b0, 3'd5, 32'h802, 32'h0, 32'h9876_0000, 3, 1'b0);

        // Stray ack while idle must not start or complete anything.
        bus_ack = 1'b1;
        tick();
        check("idle_ack.bus_req", 32'(bus_req), 32'd0);
        check("idle_ack.done", 32'(done_m), 32'd0);
        tick();
        check("idle_ack.done2", 32'(done_m), 32'd0);
        bus_ack = 1'b0;

        do_access("timeout", 1'b1, 1'b0, 3'd2, 32'h900, 32'h0, 32'h0, 0, 1'b1);

        // Reset in the middle of a request.
        mem_read_m = 1'b1;
        funct3_m   = 3'd2;
        addr_m     = 32'hA00;
        tick();
        check("mid_rst.req_before", 32'(bus_req), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst.bus_req", 32'(bus_req), 32'd0);
        check("mid_rst.stall", 32'(stall_m), 32'd0);
        check("mid_rst.done", 32'(done_m), 32'd0);
        check("mid_rst.bus_addr", bus_addr, 32'd0);
        mem_read_m = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst.no_done", 32'(done_m), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            do_access($sformatf("rnd%0d", n), rd, wr, 3'($urandom), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of REQ-state cycles without bus_ack before a bus-timeout error.
REQ-002 Port clk  input  1  clock, rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port mem_read_m  input  1  load request from the EX/MEM register.
REQ-005 Port mem_write_m  input  1  store request from the EX/MEM register.
REQ-006 Port funct3_m  input  3  access size and sign encoding.
REQ-007 Port addr_m  input  32  byte address, equal to ALUResultM.
REQ-008 Port wdata_m  input  32  store data, equal to WriteDataM.
REQ-009 Port stall_m  output  1  holds the IF..EX/MEM pipeline registers.
REQ-010 Port rdata_m  output  32  aligned and extended load result.
REQ-011 Port done_m  output  1  one-cycle pulse marking access completion.
REQ-012 Port err_m  output  1  error pulse, coincident with done_m.
REQ-013 Port err_cause_m  output  2  error cause: 00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-014 Port bus_req  output  1  data-bus request.
REQ-015 Port bus_we  output  1  1 = write.
REQ-016 Port bus_addr  output  32  word-aligned address; bits [1:0] are always 0.
REQ-017 Port bus_be  output  4  byte enables.
REQ-018 Port bus_wdata  output  32  lane-replicated store data.
REQ-019 Port bus_ack  input  1  transfer accepted or completed.
REQ-020 Port bus_rdata  input  32  read data, valid when bus_ack=1.

Function
REQ-021 The FSM SHALL have three states: IDLE, REQ, DONE.
- IDLE -> REQ when an access is requested and legal.
- IDLE -> DONE with error when the access is illegal or, with the macro defined, misaligned.
- REQ -> DONE on bus_ack=1 or on timeout.
- DONE -> IDLE unconditionally.
REQ-022 On IDLE->REQ, the unit SHALL register bus_we, bus_addr, bus_be and bus_wdata; these SHALL stay stable until bus_ack is sampled high.
REQ-023 bus_req SHALL equal 1 exactly while the state is REQ.
REQ-024 stall_m SHALL be (IDLE and (mem_read_m or mem_write_m)) or REQ; it SHALL be 0 in DONE so the upstream register advances at the end of DONE.
REQ-025 Minimum latency SHALL be 3 cycles (IDLE, REQ with ack, DONE); each wait cycle without ack adds one cycle.
REQ-026 When mem_read_m and mem_write_m are both 1, the unit SHALL perform the store only.
REQ-027 Byte enables and store data:
- SB: bus_be = 0001 << addr[1:0], byte replicated to 4 lanes.
- SH: bus_be = 0011 << 2*addr[1], halfword replicated to 2 lanes.
- SW: bus_be = 1111.
REQ-028 Loads SHALL extract the addressed lane from bus_rdata captured on ack.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes all 32 bits.
- rdata_m SHALL hold its value until the next completion.
REQ-029 A funct3 that is not a legal load or store encoding SHALL complete with err_m=1, cause 11, and no bus transaction.
REQ-030 A timeout counter SHALL clear on REQ entry and increment each REQ cycle.
- When it reaches TIMEOUT-1 without ack, the unit SHALL go to DONE with cause 10 and rdata_m=0.
- bus_req SHALL drop.
REQ-031 A bus_ack received outside REQ SHALL be ignored.

Reset
REQ-032 While reset=0, the unit SHALL go to IDLE immediately (asynchronously) and drive all outputs and registers to 0, including bus_req.
REQ-033 A reset during REQ SHALL abort the transaction with no done_m pulse.

Configuration
REQ-034 With MEM_ACCESS_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->DONE with err_m=1, cause 01, and no bus_req.
REQ-035 Without the macro, the unit SHALL ignore the misaligned low address bits (half uses addr[1] only, word uses none), SHALL never report cause 01, and SHALL perform the access.

Structure
REQ-036 The shared package riscv_pkg SHALL hold the funct3 load/store encodings, the FSM state enum and the err_cause codes.
REQ-037 A combinational sub-module lsu_align SHALL compute bus_be, the replicated wdata and the load extraction/extension.

Verification
REQ-038 SW addr 0x100, data 0xDEADBEEF, ack on 1st REQ cycle -> bus_addr=0x100, be=1111; done_m at cycle 3; stall_m high for 2 cycles.
REQ-039 LB addr 0x203, bus_rdata 0x80FFFFFF, ack after 2 waits -> rdata_m=0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SH addr 0x302, data 0x0000ABCD -> be=1100, bus_wdata=0xABCDABCD.
REQ-041 LW addr 0x401, macro defined -> err_m=1, cause 01, bus_req never 1; macro undefined -> bus_addr=0x400, be=1111.
REQ-042 LW with ack never asserted, TIMEOUT=64 -> err_m=1, cause 10, rdata_m=0; reset=0 mid-REQ -> bus_req=0 immediately, no done_m.
